traffic_rank_engine: RTL and testbench

Parametrised successor to the fixed 24-hour, 5-day rank calculator. Snapshots a per-slot traffic-count vector on START and ranks one slot per cycle against a programmable per-profile threshold table. Produces {slot, rank} records and the peak-ranked slot. Sits between the traffic counter bank and the display/report logic on SYSTEM_BUS.
Profile (day) selection advances on a midnight tick.

---
 rtl/traffic_rank_engine_pkg.sv | 36 +++
 rtl/traffic_rank_engine_if.sv | 41 ++++
 rtl/traffic_rank_engine_rank_lookup.sv | 32 +++
 rtl/traffic_rank_engine.sv | 186 ++++++++++++++++++
 tb/tb_traffic_rank_engine.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_rank_engine_pkg.sv
// traffic_rank_pkg
// Shared types and helpers for the traffic rank engine:
//   state_t       - run sequencer states
//   default_th    - threshold value loaded at reset for profile p, level k
//   pack_record   - builds a {slot, rank} record
//   record_slot / record_rank - split a record back into its fields
package traffic_rank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Reset threshold table: TH[p][k] = (k+1)*(p+1), so a higher profile index ranks more leniently
    function automatic int unsigned default_th(input int unsigned p, input int unsigned k);
        return (k + 32'd1) * (p + 32'd1);
    endfunction

    // Record layout is {slot, rank} with the rank in the low rank_w bits
    function automatic logic [31:0] pack_record(input logic [31:0] slot,
                                                input logic [31:0] rank,
                                                input int unsigned rank_w);
        return (slot << rank_w) | rank;
    endfunction

    function automatic logic [31:0] record_rank(input logic [31:0] rec, input int unsigned rank_w);
        return rec & ((32'd1 << rank_w) - 32'd1);
    endfunction

    function automatic logic [31:0] record_slot(input logic [31:0] rec, input int unsigned rank_w);
        return rec >> rank_w;
    endfunction

endpackage

// File: rtl/traffic_rank_engine_if.sv
// traffic_rank_engine_if
// Bundles the engine's SYSTEM_BUS-side signals.
//   master : the requester (counter bank / config / report side) drives START, TRAFFIC_DATA,
//            DAY_TICK and CFG_*; it observes BUSY, DONE, DAY, RANKED_DATA, PEAK_*.
//   slave  : the engine itself, the opposite directions.
interface traffic_rank_engine_if #(
    parameter int N_SLOTS    = 24,
    parameter int CNT_W      = 10,
    parameter int RANK_W     = 5,
    parameter int N_LEVELS   = 8,
    parameter int N_PROFILES = 5
) ();
    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int PROF_W = $clog2(N_PROFILES);
    localparam int LVL_W  = $clog2(N_LEVELS);

    logic                               START;
    logic [N_SLOTS*CNT_W-1:0]           TRAFFIC_DATA;
    logic                               DAY_TICK;
    logic                               CFG_WE;
    logic [PROF_W-1:0]                  CFG_PROFILE;
    logic [LVL_W-1:0]                   CFG_LEVEL;
    logic [CNT_W-1:0]                   CFG_DATA;
    logic                               BUSY;
    logic                               DONE;
    logic [PROF_W-1:0]                  DAY;
    logic [N_SLOTS*(SLOT_W+RANK_W)-1:0] RANKED_DATA;
    logic [SLOT_W-1:0]                  PEAK_SLOT;
    logic [RANK_W-1:0]                  PEAK_RANK;

    modport master (
        output START, TRAFFIC_DATA, DAY_TICK, CFG_WE, CFG_PROFILE, CFG_LEVEL, CFG_DATA,
        input  BUSY, DONE, DAY, RANKED_DATA, PEAK_SLOT, PEAK_RANK
    );

    modport slave (
        input  START, TRAFFIC_DATA, DAY_TICK, CFG_WE, CFG_PROFILE, CFG_LEVEL, CFG_DATA,
        output BUSY, DONE, DAY, RANKED_DATA, PEAK_SLOT, PEAK_RANK
    );

endinterface

// File: rtl/traffic_rank_engine_rank_lookup.sv
// rank_lookup
// Combinational rank of one count against one profile's threshold row.
//   count_i : traffic count
//   th_i    : N_LEVELS thresholds, level k at [k*CNT_W +: CNT_W]
//   rank_o  : 0 for a zero count or no match, else N_LEVELS-k for the lowest k with count <= TH[k]
module rank_lookup #(
    parameter int CNT_W    = 10,
    parameter int RANK_W   = 5,
    parameter int N_LEVELS = 8
) (
    input  logic [CNT_W-1:0]          count_i,
    input  logic [N_LEVELS*CNT_W-1:0] th_i,
    output logic [RANK_W-1:0]         rank_o
);

    // Priority encode: walk from the top level down so the lowest matching k is written last
    always_comb begin
        rank_o = '0;
        if (count_i == '0) begin
            rank_o = '0;
        end else begin
            for (int k = N_LEVELS - 1; k >= 0; k--) begin
                if (count_i <= th_i[k*CNT_W +: CNT_W]) begin
                    rank_o = RANK_W'(N_LEVELS - k);
                end else begin
                    rank_o = rank_o;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_rank_engine.sv
// traffic_rank_engine
// Snapshots a per-slot traffic vector on START and ranks one slot per cycle against the
// threshold row of the current day profile, producing {slot, rank} records and the peak slot.
// Ports:
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of traffic_rank_engine_if (START/TRAFFIC_DATA/DAY_TICK/CFG_* in,
//              BUSY/DONE/DAY/RANKED_DATA/PEAK_SLOT/PEAK_RANK out, all outputs registered)
module traffic_rank_engine
    import traffic_rank_pkg::*;
#(
    parameter int N_SLOTS    = 24,
    parameter int CNT_W      = 10,
    parameter int RANK_W     = 5,
    parameter int N_LEVELS   = 8,
    parameter int N_PROFILES = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    traffic_rank_engine_if.slave  bus
);

    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int PROF_W = $clog2(N_PROFILES);
    localparam int LVL_W  = $clog2(N_LEVELS);
    localparam int REC_W  = SLOT_W + RANK_W;

    state_t                    state_q, state_d;
    logic [SLOT_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]          snap_q [N_SLOTS];
    logic [CNT_W-1:0]          th_q [N_PROFILES][N_LEVELS];
    // Threshold row of the run profile, captured at START so that table writes and day
    // ticks in the START cycle or later cannot disturb the run in progress.
    logic [N_LEVELS*CNT_W-1:0] run_th_q;
    logic [PROF_W-1:0]         day_q;
    logic [SLOT_W-1:0]         acc_slot_q, acc_slot_d;
    logic [RANK_W-1:0]         acc_rank_q, acc_rank_d;
    logic [SLOT_W-1:0]         peak_slot_q;
    logic [RANK_W-1:0]         peak_rank_q;
    logic                      done_q;
    logic                      busy_q;
    logic [REC_W-1:0]          rec_q [N_SLOTS];
    logic [RANK_W-1:0]         rank_s;
    logic                      start_s;
    logic                      last_s;
    logic                      cfg_ok_s;

    assign start_s  = (state_q == ST_IDLE) && bus.START;
    assign last_s   = (idx_q == SLOT_W'(N_SLOTS - 1));
    assign cfg_ok_s = bus.CFG_WE && (state_q == ST_IDLE)
                      && ({1'b0, bus.CFG_PROFILE} < (PROF_W + 1)'(N_PROFILES))
                      && ({1'b0, bus.CFG_LEVEL} < (LVL_W + 1)'(N_LEVELS));

    rank_lookup #(
        .CNT_W    (CNT_W),
        .RANK_W   (RANK_W),
        .N_LEVELS (N_LEVELS)
    ) u_lookup (
        .count_i (snap_q[idx_q]),
        .th_i    (run_th_q),
        .rank_o  (rank_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic for the run sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (last_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q + SLOT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Peak tracking: strict compare so the earliest slot keeps a tied maximum
    always_comb begin
        acc_slot_d = acc_slot_q;
        acc_rank_d = acc_rank_q;
        if (rank_s > acc_rank_q) begin
            acc_slot_d = idx_q;
            acc_rank_d = rank_s;
        end else begin
            acc_slot_d = acc_slot_q;
            acc_rank_d = acc_rank_q;
        end
    end

    // Run datapath: snapshot, per-slot records, peak result, status flags and day counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                snap_q[s] <= '0;
                rec_q[s]  <= '0;
            end
            run_th_q    <= '0;
            acc_slot_q  <= '0;
            acc_rank_q  <= '0;
            peak_slot_q <= '0;
            peak_rank_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            day_q       <= '0;
        end else begin
            done_q <= (state_d == ST_FIN);
            busy_q <= (state_d == ST_LOAD) || (state_d == ST_SCAN);
            if (bus.DAY_TICK) begin
                day_q <= (day_q == PROF_W'(N_PROFILES - 1)) ? '0 : day_q + PROF_W'(1);
            end
            if (start_s) begin
                for (int s = 0; s < N_SLOTS; s++) begin
                    snap_q[s] <= bus.TRAFFIC_DATA[s*CNT_W +: CNT_W];
                end
                for (int k = 0; k < N_LEVELS; k++) begin
                    run_th_q[k*CNT_W +: CNT_W] <= th_q[day_q][k];
                end
                acc_slot_q <= '0;
                acc_rank_q <= '0;
            end
            if (state_q == ST_SCAN) begin
                rec_q[idx_q] <= REC_W'(pack_record(32'(idx_q), 32'(rank_s), RANK_W));
                acc_slot_q   <= acc_slot_d;
                acc_rank_q   <= acc_rank_d;
                if (last_s) begin
                    peak_slot_q <= acc_slot_d;
                    peak_rank_q <= acc_rank_d;
                end
            end
        end
    end

    // Threshold table: defaults on reset, writes accepted only while idle and in range
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int p = 0; p < N_PROFILES; p++) begin
                for (int k = 0; k < N_LEVELS; k++) begin
                    th_q[p][k] <= CNT_W'(default_th(p, k));
                end
            end
        end else if (cfg_ok_s) begin
            th_q[bus.CFG_PROFILE][bus.CFG_LEVEL] <= bus.CFG_DATA;
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.DAY       = day_q;
    assign bus.PEAK_SLOT = peak_slot_q;
    assign bus.PEAK_RANK = peak_rank_q;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_rec
        assign bus.RANKED_DATA[g*REC_W +: REC_W] = rec_q[g];
    end

endmodule

// File: tb/tb_traffic_rank_engine.sv
// Bench for traffic_rank_engine: directed scenarios plus a randomized phase, all checked by a
// scoreboard fed from a plain behavioural model of the ranking rules.
module tb_traffic_rank_engine;

    localparam int N_SLOTS    = 24;
    localparam int CNT_W      = 10;
    localparam int RANK_W     = 5;
    localparam int N_LEVELS   = 8;
    localparam int N_PROFILES = 5;
    localparam int SLOT_W     = $clog2(N_SLOTS);
    localparam int PROF_W     = $clog2(N_PROFILES);
    localparam int LVL_W      = $clog2(N_LEVELS);
    localparam int REC_W      = SLOT_W + RANK_W;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;

    traffic_rank_engine_if #(
        .N_SLOTS(N_SLOTS), .CNT_W(CNT_W), .RANK_W(RANK_W),
        .N_LEVELS(N_LEVELS), .N_PROFILES(N_PROFILES)
    ) bus ();

    traffic_rank_engine #(
        .N_SLOTS(N_SLOTS), .CNT_W(CNT_W), .RANK_W(RANK_W),
        .N_LEVELS(N_LEVELS), .N_PROFILES(N_PROFILES)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        int ranks[N_SLOTS];
        int pslot;
        int prank;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_day;
    int m_th[N_PROFILES][N_LEVELS];
    int run_k = -1000;
    int cnt[N_SLOTS];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_rank(input int p, input int c);
        if (c == 0) return 0;
        for (int k = 0; k < N_LEVELS; k++)
            if (c <= m_th[p][k]) return N_LEVELS - k;
        return 0;
    endfunction

    task automatic model_reset();
        m_day = 0;
        for (int p = 0; p < N_PROFILES; p++)
            for (int k = 0; k < N_LEVELS; k++)
                m_th[p][k] = (k + 1) * (p + 1);
        run_k = -1000;
        sb_q.delete();
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model to match
    task automatic step(input bit st, input bit tk, input bit we,
                        input int prof, input int lvl, input int val);
        bit   idle;
        exp_t e;
        int   best;
        @(negedge CLK);
        bus.START       = st;
        bus.DAY_TICK    = tk;
        bus.CFG_WE      = we;
        bus.CFG_PROFILE = PROF_W'(prof);
        bus.CFG_LEVEL   = LVL_W'(lvl);
        bus.CFG_DATA    = CNT_W'(val);
        for (int s = 0; s < N_SLOTS; s++)
            bus.TRAFFIC_DATA[s*CNT_W +: CNT_W] = CNT_W'(cnt[s]);
        idle = (cyc > run_k + N_SLOTS + 2);
        if (st && idle) begin
            best = 0;
            e.pslot = 0;
            for (int s = 0; s < N_SLOTS; s++) begin
                e.ranks[s] = m_rank(m_day, cnt[s]);
                if (e.ranks[s] > best) begin
                    best    = e.ranks[s];
                    e.pslot = s;
                end
            end
            e.prank    = best;
            e.done_cyc = cyc + N_SLOTS + 2;
            sb_q.push_back(e);
            run_k = cyc;
        end
        if (we && idle && prof < N_PROFILES && lvl < N_LEVELS)
            m_th[prof][lvl] = val;
        if (tk)
            m_day = (m_day == N_PROFILES - 1) ? 0 : m_day + 1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk("drain_timeout", sb_q.size(), 0);
        idle_n(2);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.START = 1'b0; bus.DAY_TICK = 1'b0; bus.CFG_WE = 1'b0;
        @(posedge CLK);
        #1 model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_day", int'(bus.DAY), 0);
        chk("rst_records_zero", int'(bus.RANKED_DATA != '0), 0);
        chk("rst_peak_slot", int'(bus.PEAK_SLOT), 0);
        chk("rst_peak_rank", int'(bus.PEAK_RANK), 0);
    endtask

    task automatic clear_cnt();
        for (int s = 0; s < N_SLOTS; s++) cnt[s] = 0;
    endtask

    // Monitor: BUSY window, rank bounds, DONE/BUSY ordering, and scoreboard pop on DONE
    bit   prev_busy = 1'b0;
    exp_t me;
    always @(negedge CLK) begin
        int  bad_s;
        bit  bound_bad;
        if (!RST) begin
            chk("busy", int'(bus.BUSY), int'((cyc >= run_k + 1) && (cyc <= run_k + N_SLOTS + 1)));
            bound_bad = (int'(bus.PEAK_RANK) > N_LEVELS);
            for (int s = 0; s < N_SLOTS; s++)
                if (int'(bus.RANKED_DATA[s*REC_W +: RANK_W]) > N_LEVELS) bound_bad = 1'b1;
            chk("assert_rank_bound", int'(bound_bad), 0);
            if (bus.DONE) begin
                chk("assert_done_after_busy", int'(prev_busy), 1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    me = sb_q.pop_front();
                    chk("done_cycle", cyc, me.done_cyc);
                    bad_s = -1;
                    for (int s = N_SLOTS - 1; s >= 0; s--)
                        if (int'(bus.RANKED_DATA[s*REC_W +: RANK_W]) != me.ranks[s] ||
                            int'(bus.RANKED_DATA[s*REC_W + RANK_W +: SLOT_W]) != s)
                            bad_s = s;
                    if (bad_s >= 0)
                        chk("record_rank", int'(bus.RANKED_DATA[bad_s*REC_W +: REC_W]),
                            (bad_s << RANK_W) | me.ranks[bad_s]);
                    else
                        chk("records", 0, 0 * bad_s - 0);
                    chk("peak_slot", int'(bus.PEAK_SLOT), me.pslot);
                    chk("peak_rank", int'(bus.PEAK_RANK), me.prank);
                end
            end
        end
        prev_busy = bus.BUSY;
    end

    initial begin
        bus.START = 1'b0; bus.DAY_TICK = 1'b0; bus.CFG_WE = 1'b0;
        bus.CFG_PROFILE = '0; bus.CFG_LEVEL = '0; bus.CFG_DATA = '0;
        bus.TRAFFIC_DATA = '0;
        clear_cnt();
        model_reset();
        do_reset();

        // default table, profile 0: ranks 8,7,6,0
        cnt[0] = 1; cnt[1] = 2; cnt[2] = 3; cnt[3] = 9;
        step(1, 0, 0, 0, 0, 0);
        drain();

        // three ticks -> profile 3, slot5=4 ranks 8
        repeat (3) step(0, 1, 0, 0, 0, 0);
        idle_n(1);
        chk("day_after_3", int'(bus.DAY), m_day);
        clear_cnt(); cnt[5] = 4; cnt[6] = 9; cnt[9] = 33;
        step(1, 0, 0, 0, 0, 0);
        drain();
        repeat (2) step(0, 1, 0, 0, 0, 0);
        idle_n(1);
        chk("day_wrap_0", int'(bus.DAY), 0);
        repeat (6) step(0, 1, 0, 0, 0, 0);
        idle_n(1);
        chk("day_wrap_1", int'(bus.DAY), 1);

        // table writes: idle write applied, busy write dropped, out-of-range dropped
        do_reset();
        step(0, 0, 1, 0, 0, 10);
        step(0, 0, 1, 6, 0, 1);
        clear_cnt(); cnt[2] = 10;
        step(1, 0, 0, 0, 0, 0);
        idle_n(4);
        step(0, 0, 1, 0, 0, 5);
        drain();
        clear_cnt(); cnt[0] = 7;
        step(1, 0, 1, 0, 0, 1);   // same-cycle write: run keeps old TH[0][0]
        drain();
        cnt[0] = 5;
        step(1, 0, 0, 0, 0, 0);   // now TH[0][0]=1 -> 5 matches level 4
        drain();

        // START ignored while busy, data change after snapshot ignored
        clear_cnt(); cnt[4] = 2; cnt[10] = 6;
        step(1, 0, 0, 0, 0, 0);
        idle_n(2);
        cnt[4] = 0; cnt[11] = 1;
        idle_n(2);
        step(1, 0, 0, 0, 0, 0);
        drain();

        // tie -> lowest slot wins; then an all-zero run; tick in the START cycle
        clear_cnt(); cnt[3] = 1; cnt[17] = 1; cnt[20] = 3;
        step(1, 1, 0, 0, 0, 0);
        drain();
        clear_cnt();
        step(1, 0, 0, 0, 0, 0);
        drain();

        // reset ten cycles into a run aborts it; defaults back afterwards
        cnt[7] = 1;
        step(1, 0, 0, 0, 0, 0);
        idle_n(9);
        do_reset();
        idle_n(30);
        clear_cnt(); cnt[0] = 1; cnt[1] = 2; cnt[2] = 3; cnt[3] = 9;
        step(1, 0, 0, 0, 0, 0);
        drain();

        // randomized traffic, ticks and table writes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int s = 0; s < N_SLOTS; s++) cnt[s] = $urandom_range(0, 45);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 45));
        end
        drain();
        chk("final_day", int'(bus.DAY), m_day);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
